// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, trap causes, SYSTEM encodings and the CSR read-modify-write rule.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

  typedef enum logic [2:0] {
    F3_PRIV = 3'b000,
    CSRRW   = 3'b001,
    CSRRS   = 3'b010,
    CSRRC   = 3'b011,
    F3_RSV  = 3'b100,
    CSRRWI  = 3'b101,
    CSRRSI  = 3'b110,
    CSRRCI  = 3'b111
  } csr_funct3_e;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MEI_BIT      = 11;

  // funct3[1:0] selects write/set/clear; funct3[2] only picks the operand source.
  function automatic logic [31:0] csr_alu(input logic [2:0] f3,
                                          input logic [31:0] old_val,
                                          input logic [31:0] op);
    logic [31:0] res;
    res = old_val;
    case (f3[1:0])
      2'b01:   res = op;
      2'b10:   res = old_val | op;
      2'b11:   res = old_val & ~op;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with increment enable and independent 32-bit half writes.
// A half write beats the increment for that half; a write to the low half drops the carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        carry;

  assign carry = inc_en & (&lo_q);

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_lo)       lo_d = wdata;
    else if (inc_en) lo_d = lo_q + 32'd1;
    if (wr_hi)                hi_d = wdata;
    else if (carry && !wr_lo) hi_d = hi_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign value = {hi_q, lo_q};

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: CSR access, ecall/ebreak/interrupt
// trap entry, mret, and fetch redirect for the single-cycle core.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        csr_w_en,
  input  logic        ret,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        irq_ext,
  output logic [31:0] csr_rdata,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic        kill
);

  logic        meip_s1_q, meip_s2_q;
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle, minstret;

  logic        sys_ecall, sys_ebreak, sys_mret;
  logic        irq_pend, take_trap, take_mret, csr_wr;
  logic [31:0] op_val, wdata, trap_cause;

  assign sys_ecall  = instr_valid & ret & (csr_addr == F12_ECALL);
  assign sys_ebreak = instr_valid & ret & (csr_addr == F12_EBREAK);
  assign sys_mret   = instr_valid & ret & (csr_addr == F12_MRET);

  // Priority: interrupt, then exception, then mret, then CSR write.
  assign irq_pend   = meip_s2_q & meie_q & mie_q & instr_valid;
  assign take_trap  = irq_pend | sys_ecall | sys_ebreak;
  assign take_mret  = ~take_trap & sys_mret;
  assign csr_wr     = instr_valid & csr_w_en & (funct3[1:0] != 2'b00) & ~take_trap & ~sys_mret;
  assign trap_cause = irq_pend ? CAUSE_MEI : (sys_ecall ? CAUSE_ECALL_M : CAUSE_BREAK);

  assign op_val = funct3[2] ? {27'b0, zimm} : rs1_data;
  assign wdata  = csr_alu(funct3, csr_rdata, op_val);

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:                 csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CSR_MIE:                     csr_rdata = {20'b0, meie_q, 11'b0};
      CSR_MTVEC:                   csr_rdata = mtvec_q;
      CSR_MSCRATCH:                csr_rdata = mscratch_q;
      CSR_MEPC:                    csr_rdata = mepc_q;
      CSR_MCAUSE:                  csr_rdata = mcause_q;
      CSR_MIP:                     csr_rdata = {20'b0, meip_s2_q, 11'b0};
      CSR_MCYCLE,   CSR_CYCLE:     csr_rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    csr_rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   csr_rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
      CSR_MHARTID:                 csr_rdata = HART_ID;
      default:                     csr_rdata = '0;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (take_trap) begin
      mepc_d   = pc & ~32'h3;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (take_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wdata[MSTATUS_MIE];
          mpie_d = wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      meie_d     = wdata[MEI_BIT];
        CSR_MTVEC:    mtvec_d    = wdata & ~32'h3;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata & ~32'h3;
        CSR_MCAUSE:   mcause_d   = wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meip_s1_q  <= 1'b0;
      meip_s2_q  <= 1'b0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      meip_s1_q  <= irq_ext;
      meip_s2_q  <= meip_s1_q;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .wr_lo  (csr_wr & (csr_addr == CSR_MCYCLE)),
    .wr_hi  (csr_wr & (csr_addr == CSR_MCYCLEH)),
    .wdata  (wdata),
    .value  (mcycle)
  );

  // A trapped instruction does not retire.
  csr_counter64 u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (instr_valid & ~take_trap),
    .wr_lo  (csr_wr & (csr_addr == CSR_MINSTRET)),
    .wr_hi  (csr_wr & (csr_addr == CSR_MINSTRETH)),
    .wdata  (wdata),
    .value  (minstret)
  );

  assign redirect_en = rst_n & (take_trap | take_mret);
  assign kill        = rst_n & take_trap;
  assign redirect_pc = !rst_n    ? 32'd0 :
                       take_trap ? mtvec_q :
                       take_mret ? mepc_q : 32'd0;

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the single-cycle core.
- Executes the csr_w_en and ret controls produced by instruction decode: performs CSR reads and writes, takes ecall, ebreak and external-interrupt traps, executes mret, and redirects fetch.
- Sits beside the ALU and register file. Its read data feeds the reg_w_sel=11 writeback path.

Parameters:
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec (bits [1:0] forced 0).
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  an instruction is executing this cycle
- pc  in  32  PC of the executing instruction
- csr_w_en  in  1  CSR instruction (decode control)
- ret  in  1  SYSTEM funct3=000 instruction (decode control)
- funct3  in  3  instruction funct3
- csr_addr  in  12  instr[31:20]; also funct12 when ret=1
- rs1_data  in  32  register operand
- zimm  in  5  instr[19:15] immediate operand
- irq_ext  in  1  asynchronous external interrupt request
- csr_rdata  out  32  old CSR value, for writeback
- redirect_en  out  1  fetch must load redirect_pc next edge
- redirect_pc  out  32  trap vector or mepc
- kill  out  1  squash the current instruction's reg/dmem writes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - All CSRs are 0, except mtvec=MTVEC_RESET and mstatus.MPP, which always reads 2'b11.
  - Synchronizer flops are 0.
  - While rst_n=0: redirect_en=0, kill=0, redirect_pc=0.
- Timing: outputs are combinational from inputs and state; all state updates on the posedge clk.
- Implemented CSRs (unlisted addresses read 0 and ignore writes):
  - mstatus 0x300: MIE[3], MPIE[7].
  - mie 0x304: MEIE[11].
  - mtvec 0x305: direct mode only.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mip 0x344: MEIP[11], read-only.
  - mcycle 0xB00 / mcycleh 0xB80.
  - minstret 0xB02 / minstreth 0xB82.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows of the machine counters.
  - mhartid 0xF14: read-only.
- CSR operations (csr_w_en=1), by funct3:
  - 001 RW and 101 RWI: new = op.
  - 010 RS and 110 RSI: new = old | op.
  - 011 RC and 111 RCI: new = old & ~op.
  - op = rs1_data for funct3[2]=0, {27'b0, zimm} for funct3[2]=1.
  - csr_rdata always returns the pre-write value.
  - Writes to read-only addresses are silently dropped.
- SYSTEM (ret=1), decoded on csr_addr:
  - 0x000 ecall: cause 11.
  - 0x001 ebreak: cause 3.
  - 0x302 mret.
  - Any other value is a no-op.
- Interrupt path:
  - irq_ext passes a 2-flop synchronizer into mip.MEIP (2-cycle latency).
  - irq_pend = MEIP & mie.MEIE & mstatus.MIE & instr_valid.
- Event priority within a cycle: irq_pend > ecall/ebreak > mret > CSR write. Lower-priority events are suppressed.
- Trap entry (irq or exception):
  - redirect_en=1, redirect_pc=mtvec & ~3.
  - At the edge: mepc<=pc, mcause<=cause, MPIE<=MIE, MIE<=0.
  - Interrupt cause = 32'h8000_000B, and kill=1 (the instruction is not executed, so mepc re-executes it).
  - Exceptions also assert kill=1.
- mret:
  - redirect_en=1, redirect_pc=mepc.
  - At the edge: MIE<=MPIE, MPIE<=1.
- Counters:
  - mcycle is 64-bit, increments every cycle out of reset and wraps at 2^64.
  - minstret increments when instr_valid & ~kill.
  - A CSR write to either 32-bit half in the same cycle wins over the increment for that half. The carry into the other half from that cycle is dropped.
- A CSR write to mstatus.MIE takes effect for the next instruction. irq_pend in the writing cycle uses the old value.
- Reset asserted mid-cycle aborts any pending update. No partial trap state is retained.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants.
  - Cause codes (CAUSE_ECALL_M=11, CAUSE_BREAK=3, CAUSE_MEI=32'h8000_000B).
  - funct3 encodings (CSRRW..CSRRCI).
  - funct12 codes (ECALL, EBREAK, MRET).
  - mstatus bit indices.
- One sub-module, csr_counter64: 64-bit counter with increment enable and independent lo/hi write ports. It is instantiated for mcycle and minstret.

Test Plan:
- Reset:
  - Stimulus: release rst_n, read 0x305, 0x300, 0xF14.
  - Required: 32'h100, 32'h1800 (MPP=11), 0.
- CSR read-modify-write on mscratch:
  - Stimulus: CSRRW 0x340 with rs1_data=32'hA5A5_0000, then CSRRS with zimm=5'h0F, then CSRRC with rs1_data=32'h0000_0005.
  - Required: csr_rdata returns 0, then 32'hA5A5_0000, then 32'hA5A5_000F; final value 32'hA5A5_000A.
- ecall:
  - Stimulus: ecall at pc=32'h200 with mtvec=32'h103.
  - Required: redirect_pc=32'h100, kill=1, mepc=32'h200, mcause=11, MIE cleared.
  - Follow with mret: redirect_pc=32'h200, MIE restored.
- External interrupt:
  - Stimulus: MIE=1, MEIE=1, raise irq_ext.
  - Required: redirect_en on the 3rd instruction edge after the raise, mcause=32'h8000_000B, mepc = that instruction's pc, minstret not incremented. Same event with MIE=0: no redirect.
- Priority:
  - Stimulus: irq_pend in the same cycle as a CSRRW to mscratch.
  - Required: interrupt taken, mscratch unchanged.
- Counter wrap and write collision:
  - Stimulus: write mcycleh=32'hFFFF_FFFF and mcycle=32'hFFFF_FFFF.
  - Required: next cycle reads 0 / 0.
  - Stimulus: write mcycle=5 in an increment cycle.
  - Required: reads 5, then 6.
